fc_layer_seq: RTL and testbench
===============================

Name: fc_layer_seq

Overview:
- Sequencer for the combinational fully-connected neuron blocks (constant-weight booth multipliers, adder tree, ReLU).
- Collects one input activation vector serially over a valid/ready stream and holds it stable on the datapath inputs.
- Waits a fixed settle/pipeline latency, then captures all OUT neuron results in one cycle.
- Streams the captured results out one per handshake, tagged with neuron index and last flag.

Parameters:
- WIDTH, 8, activation width in bits.
- IN, 128, input vector length.
- OUT, 10, number of neuron instances driven in parallel.
- ZW, WIDTH*2+$clog2(IN), width of one neuron result.
- LAT, 1, cycles from vector-complete to result capture; range 0..15.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. Synchronous, active-high.
- in_valid  input  1  activation word valid.
- in_ready  output  1  block accepts an activation word.
- in_data  input  WIDTH  activation word; element index advances by one per handshake.
- in_last  input  1  marks the final word of a frame.
- x  output  WIDTH x IN  unpacked array [0:IN-1]; vector to all neuron blocks.
- res  input  ZW x OUT  unpacked array [0:OUT-1]; neuron results.
- out_valid  output  1  result word valid.
- out_ready  input  1  downstream accepts the result word.
- out_data  output  ZW  result word.
- out_idx  output  $clog2(OUT)  neuron index of out_data.
- out_last  output  1  out_idx == OUT-1.
- busy  output  1  high in every state except LOAD with wr_idx==0.
- err_len  output  1  sticky frame-length error.

Behaviour:
Reset (rst high at a clk edge):
- state=LOAD, wr_idx=0, x all 0, result register 0.
- in_ready=1, out_valid=0, out_idx=0, err_len=0, busy=0.
- A reset asserted in any state aborts the frame; partial data is discarded.

LOAD:
- in_ready=1.
- On each in_valid&in_ready: x[wr_idx]<=in_data, then wr_idx++.
- Frame ends on accepting in_last, or on accepting word IN-1.
- Early in_last (wr_idx<IN-1): x[wr_idx+1..IN-1] are zeroed in the same edge and err_len<=1.
- Word IN-1 accepted without in_last: frame ends, err_len<=1, and the next word starts a new frame.
- At frame end: wr_idx<=0 and go to WAIT with wcnt<=LAT.

WAIT:
- in_ready=0; x is held.
- wcnt decrements each cycle; when wcnt==0, go to CAPTURE.
- With LAT=0, WAIT lasts exactly one cycle (wcnt loaded as 0).

CAPTURE (one cycle):
- rbuf[k]<=res[k] for every k.
- out_idx<=0; go to DRAIN.
- x is held through this cycle.

DRAIN:
- out_valid=1, out_data=rbuf[out_idx], out_last=(out_idx==OUT-1).
- On out_valid&out_ready: out_idx++.
- On the handshake with out_last: out_valid<=0, go to LOAD.
- out_data, out_idx and out_valid are stable while out_ready is low.
- in_ready=0 throughout DRAIN; there is no input/output overlap.

Timing:
- First out_valid rises LAT+2 cycles after the edge that accepts the final input word.

Arithmetic:
- No arithmetic on results; rbuf copies res bit-exact (ZW bits).
- err_len clears only on rst.

Test Plan:
- IN=4, OUT=3, LAT=1; feed words 1,2,3,4 with in_last on 4 and res model = {10,20,30} -> x={1,2,3,4}; out_valid rises 3 cycles after the edge accepting word 4; outputs (0,10),(1,20),(2,30,last); err_len=0.
- Same setup with out_ready toggling 1,0,0,1,... -> no output is lost or duplicated; out_data held during stalls; return to LOAD after the last handshake.
- Early in_last on the second word (5,6) -> x={5,6,0,0}, err_len=1, and the result sequence still completes.
- Four words with no in_last, then a fresh frame 9,9,9,9 with last -> first frame processed, err_len=1, second frame processed normally.
- Assert rst during DRAIN at out_idx=1 -> next cycle out_valid=0, in_ready=1, busy=0, x=0, err_len=0.
- LAT=0, in_valid held high continuously -> in_ready drops right after the frame ends; first out_valid 2 cycles after the final accept; no word is accepted during WAIT, CAPTURE or DRAIN.

Source files
------------

// File: rtl/fc_layer_seq.sv
// Sequencer around the combinational fully-connected neuron blocks: serially loads one
// activation vector, waits for the datapath to settle, captures all results, then streams them out.

module fc_rbuf_lane #(
    parameter int ZW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap,
    input  logic [ZW-1:0] d,
    output logic [ZW-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)      q <= '0;
        else if (cap) q <= d;
    end
endmodule

module fc_layer_seq #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int OUT   = 10,
    parameter int ZW    = WIDTH*2 + $clog2(IN),
    parameter int LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic [WIDTH-1:0]       x [0:IN-1],
    input  logic [ZW-1:0]          res [0:OUT-1],
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ZW-1:0]          out_data,
    output logic [$clog2(OUT)-1:0] out_idx,
    output logic                   out_last,
    output logic                   busy,
    output logic                   err_len
);
    localparam int AW  = (IN > 1) ? $clog2(IN) : 1;
    localparam int OIW = $clog2(OUT);

    typedef enum logic [1:0] {LOAD, WAIT, CAPTURE, DRAIN} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   wr_idx;
    logic [3:0]      wcnt;
    logic            acc, frame_end, at_end;
    logic [ZW-1:0]   rbuf [0:OUT-1];

    assign at_end    = (wr_idx == AW'(IN-1));
    assign acc       = in_valid & in_ready;
    assign frame_end = acc & (in_last | at_end);
    assign out_last  = (out_idx == OIW'(OUT-1));
    assign out_data  = rbuf[out_idx];

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = (wr_idx != '0);
                if (frame_end) state_nx = WAIT;
            end
            WAIT:    if (wcnt == '0) state_nx = CAPTURE;
            CAPTURE: state_nx = DRAIN;
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && out_last) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    // A frame is well formed only when in_last lands exactly on word IN-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx  <= '0;
            wcnt    <= '0;
            err_len <= 1'b0;
        end else begin
            if (acc) wr_idx <= frame_end ? '0 : wr_idx + 1'b1;
            if (frame_end && !(in_last && at_end)) err_len <= 1'b1;
            if (frame_end)
                wcnt <= 4'(LAT);
            else if (state == WAIT && wcnt != '0)
                wcnt <= wcnt - 1'b1;
        end
    end

    // Early in_last zero-fills the tail so stale elements never reach the neurons.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < IN; k++) x[k] <= '0;
        end else if (acc) begin
            for (int k = 0; k < IN; k++) begin
                if (AW'(k) == wr_idx)
                    x[k] <= in_data;
                else if (in_last && k > int'(wr_idx))
                    x[k] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_idx <= '0;
        else if (state == CAPTURE)
            out_idx <= '0;
        else if (state == DRAIN && out_ready)
            out_idx <= out_last ? '0 : out_idx + 1'b1;
    end

    for (genvar k = 0; k < OUT; k++) begin : g_lane
        fc_rbuf_lane #(.ZW(ZW)) u_lane (
            .clk (clk),
            .rst (rst),
            .cap (state == CAPTURE),
            .d   (res[k]),
            .q   (rbuf[k])
        );
    end
endmodule

// File: tb/tb_fc_layer_seq.sv
// Drives a LAT=0 and a LAT=1 instance with identical stimulus; each is checked every cycle
// against a frame/queue level model of what the sequencer must emit and when.

module tb_fc_layer_seq;
    localparam int W   = 8;
    localparam int IN  = 4;
    localparam int OUT = 3;
    localparam int ZW  = W*2 + $clog2(IN);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_last  = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         out_ready = 1'b0;
    int           orm = 0;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    bit           mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int u, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[u%0d] got %0d want %0d (cyc %0d)", nm, u, act, exp, cyc);
        end
    endtask

    // out_ready modes: 0 always, 1 pattern 1,0,0, 2 random
    always @(posedge clk) begin
        #1;
        case (orm)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int LAT = g;
        logic                   in_ready, out_valid, out_last, busy, err_len;
        logic [W-1:0]           x [0:IN-1];
        logic [ZW-1:0]          res [0:OUT-1];
        logic [ZW-1:0]          res_c [0:OUT-1];
        logic [ZW-1:0]          out_data;
        logic [$clog2(OUT)-1:0] out_idx;
        int                     s;

        fc_layer_seq #(.WIDTH(W), .IN(IN), .OUT(OUT), .ZW(ZW), .LAT(LAT)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .in_data(in_data), .in_last(in_last), .x(x), .res(res),
            .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
            .out_idx(out_idx), .out_last(out_last), .busy(busy), .err_len(err_len)
        );

        // neuron k computes (k+1) * sum(x)
        always_comb begin
            s = 0;
            for (int i = 0; i < IN; i++) s += int'(x[i]);
            for (int k = 0; k < OUT; k++) res_c[k] = ZW'((k + 1) * s);
        end
        if (LAT == 0) begin : comb
            always_comb for (int k = 0; k < OUT; k++) res[k] = res_c[k];
        end else begin : pipe
            always @(posedge clk) for (int k = 0; k < OUT; k++) res[k] <= res_c[k];
        end

        int q_data[$];
        int q_idx[$];
        int cur[$];
        int log_d[$];
        int exp_x[IN];
        bit err_m = 1'b0;
        int ready_at = 0;
        int last_acc = 0;
        int rise_lat = -1;
        bit pv = 1'b0;

        always @(negedge clk) begin : mon
            bit ir_e, ov_e;
            int sum;
            if (mon_en) begin
                ir_e = (q_data.size() == 0);
                ov_e = !ir_e && (cyc >= ready_at);
                chk("in_ready", g, in_ready, ir_e);
                chk("busy", g, busy, (cur.size() != 0) || !ir_e);
                chk("err_len", g, err_len, err_m);
                chk("out_valid", g, out_valid, ov_e);
                if (ov_e && out_valid) begin
                    chk("out_data", g, out_data, q_data[0]);
                    chk("out_idx", g, out_idx, q_idx[0]);
                    chk("out_last", g, out_last, q_idx[0] == OUT-1);
                end
                if (cur.size() == 0)
                    for (int i = 0; i < IN; i++) chk("x", g, x[i], exp_x[i]);
                if (out_valid && !pv) rise_lat = cyc - last_acc;
                pv = out_valid;

                if (rst) begin
                    q_data.delete(); q_idx.delete(); cur.delete();
                    err_m = 1'b0;
                    for (int i = 0; i < IN; i++) exp_x[i] = 0;
                end else begin
                    if (ov_e && out_ready) begin
                        log_d.push_back(q_data[0]);
                        void'(q_data.pop_front());
                        void'(q_idx.pop_front());
                    end
                    if (ir_e && in_valid) begin
                        cur.push_back(int'(in_data));
                        if (in_last || cur.size() == IN) begin
                            if (!(in_last && cur.size() == IN)) err_m = 1'b1;
                            sum = 0;
                            for (int i = 0; i < IN; i++) begin
                                exp_x[i] = (i < cur.size()) ? cur[i] : 0;
                                sum += exp_x[i];
                            end
                            for (int k = 0; k < OUT; k++) begin
                                q_data.push_back((k + 1) * sum);
                                q_idx.push_back(k);
                            end
                            last_acc = cyc + 1;
                            ready_at = cyc + 1 + LAT + 2;
                            cur.delete();
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(gi[0].in_ready && gi[1].in_ready && !gi[0].busy && !gi[1].busy) && n < 300) begin
            tick(); n++;
        end
        if (n >= 300) chk("idle_timeout", 0, 1, 0);
    endtask

    task automatic send(input int w[IN], input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = W'(w[i]);
            in_last  = last && (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic clear_logs();
        gi[0].log_d.delete();
        gi[1].log_d.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 1, gi[1].out_valid, 0);
        chk("rst_in_ready", 1, gi[1].in_ready, 1);
        chk("rst_busy", 0, gi[0].busy, 0);
        chk("rst_err", 0, gi[0].err_len, 0);
        tick();

        // basic frame 1,2,3,4 -> 10,20,30
        orm = 0;
        wait_idle(); clear_logs();
        send('{1, 2, 3, 4}, 4, 1'b1);
        wait_idle();
        chk("t1_n", 1, gi[1].log_d.size(), 3);
        if (gi[1].log_d.size() == 3) begin
            chk("t1_d0", 1, gi[1].log_d[0], 10);
            chk("t1_d1", 1, gi[1].log_d[1], 20);
            chk("t1_d2", 1, gi[1].log_d[2], 30);
        end
        chk("t1_lat", 1, gi[1].rise_lat, 3);
        chk("t1_lat", 0, gi[0].rise_lat, 2);
        for (int i = 0; i < IN; i++) chk("t1_x", 1, gi[1].x[i], i + 1);
        chk("t1_err", 1, gi[1].err_len, 0);

        // stalled drain
        orm = 1;
        clear_logs();
        send('{7, 8, 9, 10}, 4, 1'b1);
        wait_idle();
        chk("t2_n", 0, gi[0].log_d.size(), 3);
        chk("t2_n", 1, gi[1].log_d.size(), 3);

        // early in_last on second word
        orm = 0;
        clear_logs();
        send('{5, 6, 0, 0}, 2, 1'b1);
        wait_idle();
        chk("t3_x0", 1, gi[1].x[0], 5);
        chk("t3_x1", 1, gi[1].x[1], 6);
        chk("t3_x2", 1, gi[1].x[2], 0);
        chk("t3_x3", 1, gi[1].x[3], 0);
        chk("t3_err", 1, gi[1].err_len, 1);
        chk("t3_n", 1, gi[1].log_d.size(), 3);

        // overlong frame then a clean one
        clear_logs();
        send('{1, 2, 3, 4}, 4, 1'b0);
        wait_idle();
        send('{9, 9, 9, 9}, 4, 1'b1);
        wait_idle();
        chk("t4_n", 1, gi[1].log_d.size(), 6);
        if (gi[1].log_d.size() == 6) chk("t4_last", 1, gi[1].log_d[5], 108);
        chk("t4_err", 1, gi[1].err_len, 1);

        // reset mid-drain at out_idx 1
        send('{3, 1, 4, 1}, 4, 1'b1);
        n = 0;
        while (!(gi[1].out_valid && gi[1].out_idx == 1) && n < 50) begin tick(); n++; end
        if (n >= 50) chk("t5_timeout", 1, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", 1, gi[1].out_valid, 0);
        chk("t5_in_ready", 1, gi[1].in_ready, 1);
        chk("t5_busy", 1, gi[1].busy, 0);
        chk("t5_err", 1, gi[1].err_len, 0);
        for (int i = 0; i < IN; i++) chk("t5_x", 1, gi[1].x[i], 0);
        tick();

        // in_valid held high, random data and frame lengths
        orm = 2;
        for (int c = 0; c < 300; c++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_last  = ($urandom_range(0, 3) == 0);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        wait_idle();

        // bursty in_valid
        for (int c = 0; c < 400; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            in_last  = ($urandom_range(0, 4) == 0);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        wait_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
